// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared constants and types for the instruction fetch front end
package ifu_fetch_pkg;

    // Pipeline stall vector layout.
    localparam int STALL_WIDTH = 3;
    localparam int STALL_PC    = 0;
    localparam int STALL_ID    = 1;
    localparam int STALL_EX    = 2;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Core reset vector; the fetch unit's RESET_PC defaults to it.
    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifu_fetch_buf.sv
// rtl/ifu_fetch_buf.sv - in-order fetch buffer with alloc/fill/pop pointers
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             drop every entry (redirect)
//   alloc, alloc_addr reserve the entry at wr_ptr for a granted fetch
//   fill, fill_data   write a response into the oldest unfilled entry
//   pop               retire the head entry
//   full              all entries allocated
//   head_valid        head entry holds a returned instruction
//   head_addr/data    head entry contents
//   pend_cnt          allocated entries still waiting for their response
module ifu_fetch_buf
    import ifu_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          alloc,
    input  logic [31:0]   alloc_addr,
    input  logic          fill,
    input  logic [31:0]   fill_data,
    input  logic          pop,
    output logic          full,
    output logic          head_valid,
    output logic [31:0]   head_addr,
    output logic [31:0]   head_data,
    output logic [CW-1:0] pend_cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             fill_ok;

    // A response with nothing outstanding is a bus protocol error; it is dropped.
    assign fill_ok    = fill && (pend_cnt != '0);
    assign full       = (count == CW'(DEPTH));
    assign head_valid = filled_q[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    // Pointer width is log2(DEPTH) with DEPTH a power of two, so increments wrap naturally.
    // alloc, fill and pop never target the same slot: alloc needs a free slot,
    // fill an unfilled one, pop a filled one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filled_q <= '0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
        end else if (clear) begin
            filled_q <= '0;
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pend_cnt <= '0;
        end else begin
            if (alloc) begin
                filled_q[wr_ptr] <= 1'b0;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (fill_ok) begin
                filled_q[fill_ptr] <= 1'b1;
                fill_ptr           <= fill_ptr + 1'b1;
            end
            if (pop) begin
                filled_q[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + 1'b1;
            end
            count    <= count + CW'(alloc) - CW'(pop);
            pend_cnt <= pend_cnt + CW'(alloc) - CW'(fill_ok);
        end
    end

    // Payload storage needs no reset; filled_q qualifies it.
    always_ff @(posedge clk) begin
        if (alloc && !clear) begin
            addr_q[wr_ptr] <= alloc_addr;
        end
        if (fill_ok && !clear) begin
            data_q[fill_ptr] <= fill_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch front end: PC, bus request gating, stale-response dropping
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   jump_flag_i, jump_addr_i  redirect request and word-aligned target
//   stall_i                   stall vector; STALL_PC blocks issue, STALL_ID blocks pop
//   ibus_req_o, ibus_addr_o   fetch request at the current PC
//   ibus_gnt_i                request accepted this cycle
//   ibus_rvalid_i/rdata_i     in-order fetch response
//   inst_o, inst_addr_o       head instruction and its address (NOP/0 when not valid)
//   inst_valid_o              head entry holds a returned instruction
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CORE_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   jump_flag_i,
    input  logic [31:0]            jump_addr_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    output logic                   ibus_req_o,
    output logic [31:0]            ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [31:0]            ibus_rdata_i,
    output logic [31:0]            inst_o,
    output logic [31:0]            inst_addr_o,
    output logic                   inst_valid_o
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_next;
    logic [CW-1:0] pend_cnt;
    logic          drop_zero;
    logic          buf_full;
    logic          head_valid;
    logic [31:0]   head_addr;
    logic [31:0]   head_data;
    logic          alloc;
    logic          fill;
    logic          fill_ok;
    logic          pop;
    logic          unused_stall;

    assign unused_stall = ^stall_i[STALL_WIDTH-1:STALL_ID+1];

    assign drop_zero = (drop_cnt == '0);

    // Request is held low in reset so the bus sees no request while rst is high.
    assign ibus_req_o  = !rst && !buf_full && !stall_i[STALL_PC] && !jump_flag_i && drop_zero;
    assign ibus_addr_o = pc;
    assign alloc       = ibus_req_o && ibus_gnt_i;

    // Responses belonging to a discarded fetch are swallowed while drop_cnt is non-zero.
    assign fill    = ibus_rvalid_i && drop_zero;
    assign fill_ok = fill && (pend_cnt != '0);
    assign pop     = head_valid && !stall_i[STALL_ID] && !jump_flag_i;

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head_data : INST_NOP;
    assign inst_addr_o  = head_valid ? head_addr : 32'h0;

    // An old drop is retired first; on a jump every still-unfilled entry becomes a
    // future drop, less the one this cycle's response fills.
    always_comb begin
        drop_next = drop_cnt;
        if (ibus_rvalid_i && !drop_zero) begin
            drop_next = drop_cnt - 1'b1;
        end
        if (jump_flag_i) begin
            drop_next = drop_next + (pend_cnt - CW'(fill_ok));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (jump_flag_i) begin
                pc <= jump_addr_i;
            end else if (alloc) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ibus_rvalid_i && drop_zero) begin
            assert (pend_cnt != '0);
        end
    end

    ifu_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (jump_flag_i),
        .alloc      (alloc),
        .alloc_addr (pc),
        .fill       (fill),
        .fill_data  (ibus_rdata_i),
        .pop        (pop),
        .full       (buf_full),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .pend_cnt   (pend_cnt)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized and directed bench for ifu_fetch against a queue-based reference
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int          D   = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   jump_flag_i = 1'b0;
    logic [31:0]            jump_addr_i = 32'h0;
    logic [STALL_WIDTH-1:0] stall_i = '0;
    logic                   ibus_req_o;
    logic [31:0]            ibus_addr_o;
    logic                   ibus_gnt_i = 1'b0;
    logic                   ibus_rvalid_i = 1'b0;
    logic [31:0]            ibus_rdata_i = 32'h0;
    logic [31:0]            inst_o;
    logic [31:0]            inst_addr_o;
    logic                   inst_valid_o;

    ifu_fetch #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .stall_i       (stall_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          filled;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    ment_t       m_buf[$];
    rsp_t        bus_q[$];
    logic [31:0] m_pc = RPC;
    int          m_drop = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          checks = 0;
    int          errors = 0;

    bit               gnt_v = 1'b1;
    bit [STALL_WIDTH-1:0] stall_v = '0;
    bit               jump_v = 1'b0;
    logic [31:0]      jaddr_v = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_buf.delete();
        bus_q.delete();
        m_pc     = RPC;
        m_drop   = 0;
        last_due = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, ibus_req_o, 32'd0);
        chk({tag, "_valid"}, inst_valid_o, 32'd0);
        chk({tag, "_inst"}, inst_o, INST_NOP);
        chk({tag, "_inst_addr"}, inst_addr_o, 32'd0);
        chk({tag, "_pc"}, ibus_addr_o, RPC);
    endtask

    // One clock cycle: drive inputs just after the falling edge, check outputs, advance the model.
    task automatic step();
        bit          rv;
        bit          e_req;
        bit          e_valid;
        bit          pop;
        bit          done;
        int          unf;
        int          due;
        logic [31:0] rdata;

        rv    = (bus_q.size() > 0) && (bus_q[0].due <= cyc);
        rdata = rv ? (bus_q[0].addr ^ 32'hA5A5_0000) : $urandom;
        stall_i       = stall_v;
        jump_flag_i   = jump_v;
        jump_addr_i   = jaddr_v;
        ibus_gnt_i    = gnt_v;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rdata;
        #1;

        e_req   = (m_buf.size() < D) && !stall_v[STALL_PC] && !jump_v && (m_drop == 0);
        e_valid = (m_buf.size() > 0) && m_buf[0].filled;
        chk("req", ibus_req_o, e_req);
        chk("ibus_addr", ibus_addr_o, m_pc);
        chk("inst_valid", inst_valid_o, e_valid);
        chk("inst", inst_o, e_valid ? m_buf[0].data : INST_NOP);
        chk("inst_addr", inst_addr_o, e_valid ? m_buf[0].addr : 32'h0);

        pop = e_valid && !stall_v[STALL_ID];
        if (rv) begin
            if (m_drop > 0) begin
                m_drop--;
            end else begin
                done = 1'b0;
                foreach (m_buf[i]) begin
                    if (!done && !m_buf[i].filled) begin
                        m_buf[i].filled = 1'b1;
                        m_buf[i].data   = rdata;
                        done = 1'b1;
                    end
                end
            end
            void'(bus_q.pop_front());
        end
        if (jump_v) begin
            unf = 0;
            foreach (m_buf[i]) if (!m_buf[i].filled) unf++;
            m_drop += unf;
            m_buf.delete();
            m_pc = jaddr_v;
        end else begin
            if (pop) void'(m_buf.pop_front());
            if (e_req && gnt_v) begin
                m_buf.push_back('{addr: m_pc, data: 32'h0, filled: 1'b0});
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                bus_q.push_back('{addr: m_pc, due: due});
                m_pc = m_pc + 32'd4;
            end
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic mid_reset();
        rst           = 1'b1;
        ibus_rvalid_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        last_due = cyc;
    endtask

    initial begin
        // Reset state
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Free run, 1-cycle response latency
        lat_min = 1; lat_max = 1;
        run(12);

        // ID stall fills the buffer, then release
        stall_v = '0; stall_v[STALL_ID] = 1'b1;
        run(5);
        stall_v = '0;
        run(6);

        // Grant withheld with request pending
        gnt_v = 1'b0;
        run(3);
        gnt_v = 1'b1;
        run(4);

        // Jump with responses outstanding at 3-cycle latency
        lat_min = 3; lat_max = 3;
        run(4);
        jump_v = 1'b1; jaddr_v = 32'h0000_8000;
        step();
        jump_v = 1'b0;
        run(10);

        // Jump coinciding with a response and a head pop
        lat_min = 1; lat_max = 1;
        run(5);
        jump_v = 1'b1; jaddr_v = 32'h0000_0100;
        step();
        jump_v = 1'b0;
        run(5);

        // PC wrap at the top of the address space
        jump_v = 1'b1; jaddr_v = 32'hFFFF_FFF8;
        step();
        jump_v = 1'b0;
        run(6);

        // Reset with requests outstanding
        lat_min = 3; lat_max = 3;
        run(3);
        mid_reset();
        lat_min = 1; lat_max = 1;
        run(6);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 600; i++) begin
            gnt_v   = ($urandom_range(0, 3) != 0);
            stall_v = '0;
            stall_v[STALL_PC] = ($urandom_range(0, 5) == 0);
            stall_v[STALL_ID] = ($urandom_range(0, 3) == 0);
            stall_v[STALL_EX] = $urandom_range(0, 1);
            jump_v  = ($urandom_range(0, 14) == 0);
            jaddr_v = $urandom & 32'hFFFF_FFFC;
            step();
            if (i == 300) mid_reset();
        end
        jump_v = 1'b0; stall_v = '0; gnt_v = 1'b1;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
